// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, word-addressed data memory between the
// core load/store path (port 0) and the loader/debug path (port 1), round-robin.
module dmem_arbiter #(
  parameter int DEPTH = 256,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic [31:0]   mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_next;

  logic          last_grant;
  logic          win_id;
  logic          win_we;
  logic          win_bad;
  logic [AW-1:0] win_idx;
  logic [DW-1:0] win_wdata;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

  logic          grant;
  logic          grant_id;
  logic          grant_we;
  logic          grant_bad;
  logic [AW-1:0] grant_addr;
  logic [AW-1:0] grant_idx;
  logic [DW-1:0] grant_wdata;
  logic [DW-1:0] resp_data;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant       = req0 | req1;
    grant_id    = (req0 && req1) ? ~last_grant : req1;
    grant_we    = grant_id ? we1 : we0;
    grant_addr  = grant_id ? addr1 : addr0;
    grant_wdata = grant_id ? wdata1 : wdata0;
    grant_idx   = grant_addr >> 2;
    grant_bad   = (grant_addr[1:0] != 2'b00) || (grant_idx >= AW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Winner's request is captured at the grant edge; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      win_id     <= 1'b0;
      win_we     <= 1'b0;
      win_bad    <= 1'b0;
      win_idx    <= '0;
      win_wdata  <= '0;
    end else if (state == IDLE && grant) begin
      last_grant <= grant_id;
      win_id     <= grant_id;
      win_we     <= grant_we;
      win_bad    <= grant_bad;
      win_idx    <= grant_idx;
      win_wdata  <= grant_wdata;
    end
  end

  assign resp_data = (win_we || win_bad) ? '0 : mem_read_data;

  // Each port's read data persists until that port's next acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == RESP) begin
      if (win_id) begin
        rdata1_q <= resp_data;
      end else begin
        rdata0_q <= resp_data;
      end
    end
  end

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    ack0           = 1'b0;
    ack1           = 1'b0;
    err0           = 1'b0;
    err1           = 1'b0;
    rdata0         = rdata0_q;
    rdata1         = rdata1_q;
    busy           = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_address    = 32'(win_idx);
        mem_write_data = win_wdata;
        mem_read       = ~win_bad & ~win_we;
        mem_write      = ~win_bad & win_we;
      end
      RESP: begin
        if (win_id) begin
          ack1   = 1'b1;
          err1   = win_bad;
          rdata1 = resp_data;
        end else begin
          ack0   = 1'b1;
          err0   = win_bad;
          rdata0 = resp_data;
        end
      end
      default: begin
      end
    endcase
  end

  a_ack_exclusive: assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
  a_strobe_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
  a_strobe_access: assert property (@(posedge clk) disable iff (rst)
                                    (mem_read || mem_write) |-> (state == ACCESS));

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, multi-cycle arbitration sequences and a
// randomized phase checked against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_write_data;
  logic        mem_read, mem_write;
  logic [31:0] mem_read_data;
  logic        busy;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // Single-port memory with one-cycle registered read.
  logic [31:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_read_data = 32'h0;
  end
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    if (mem_read) mem_read_data <= mem[mem_address[7:0]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          strobe_cnt = 0;
  logic [31:0] strobe_addr, strobe_wdata;
  logic        strobe_we;

  always @(posedge clk) begin
    if (mem_read || mem_write) begin
      strobe_cnt++;
      strobe_addr  = mem_address;
      strobe_wdata = mem_write_data;
      strobe_we    = mem_write;
    end
    n_checks++;
    if ((ack0 && ack1) || (mem_read && mem_write) || ((mem_read || mem_write) && !busy)) begin
      n_fail++;
      $display("[TB] FAIL invariant: ack0=%b ack1=%b rd=%b wr=%b busy=%b required exclusive acks/strobes only while busy",
               ack0, ack1, mem_read, mem_write, busy);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one handshake from an IDLE negedge; returns at the ack negedge with req dropped.
  task automatic applyStimulus(input bit port, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, output bit got_ack, output bit got_err,
                               output logic [31:0] got_rdata, output int lat);
    strobe_cnt = 0;
    got_ack = 1'b0; got_err = 1'b0; got_rdata = 32'h0; lat = 0;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    for (int c = 1; c <= 10 && !got_ack; c++) begin
      @(negedge clk);
      if ((!port && ack0) || (port && ack1)) begin
        got_ack   = 1'b1;
        lat       = c;
        got_err   = port ? err1 : err0;
        got_rdata = port ? rdata1 : rdata0;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] data;
  } ack_t;
  ack_t ack_log[$];

  task automatic runWindow(input int ncyc, input bit drop0, input bit drop1, input int raise1_at);
    ack_t e;
    ack_log.delete();
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (ack0) begin
        e.cyc = c; e.port = 0; e.data = rdata0; ack_log.push_back(e);
        if (drop0) req0 = 1'b0;
      end
      if (ack1) begin
        e.cyc = c; e.port = 1; e.data = rdata1; ack_log.push_back(e);
        if (drop1) req1 = 1'b0;
      end
      if (c == raise1_at) req1 = 1'b1;
    end
  endtask

  task automatic checkAck(input string name, input int idx, input int cyc, input int port,
                          input logic [31:0] data);
    if (idx >= ack_log.size()) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: ack #%0d missing, required port %0d at cycle %0d", name, idx, port, cyc);
    end else begin
      checkOutput({name, "_cycle"}, ack_log[idx].cyc, cyc);
      checkOutput({name, "_port"}, ack_log[idx].port, port);
      checkOutput({name, "_rdata"}, ack_log[idx].data, data);
    end
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          exp_strobes;
  } vec_t;
  vec_t vecs[14];

  function automatic logic [31:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)       randAddr = 32'($urandom_range(0, 15) * 4);
    else if (r < 7)  randAddr = 32'($urandom_range(0, 255) * 4);
    else if (r == 7) randAddr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
    else if (r == 8) randAddr = 32'h400 + 32'($urandom_range(0, 1000) * 4);
    else             randAddr = 32'h3FC;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          got_ack, got_err;
    logic [31:0] got_rdata;
    int          lat;
    logic [31:0] ref_mem [0:255];
    bit          pend [2];
    bit          r_we [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    bit          just_done [2];
    int          next_slot, exp_ack_cyc, exp_port, last;
    bit          x_we, x_bad;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic [1:0]  exp_acks;

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack0", ack0, 0);
    checkOutput("rst_ack1", ack1, 0);
    checkOutput("rst_err0", err0, 0);
    checkOutput("rst_err1", err1, 0);
    checkOutput("rst_rdata0", rdata0, 0);
    checkOutput("rst_rdata1", rdata1, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_mem_wdata", mem_write_data, 0);
    rst = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1};
    vecs[2]  = '{1'b1, 1'b1, 32'h20,       32'h12345678, 1'b0, 32'h0,        1};
    vecs[3]  = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'h12345678, 1};
    vecs[4]  = '{1'b1, 1'b0, 32'h400,      32'h0,        1'b1, 32'h0,        0};
    vecs[5]  = '{1'b1, 1'b0, 32'h13,       32'h0,        1'b1, 32'h0,        0};
    vecs[6]  = '{1'b1, 1'b1, 32'h3FC,      32'hCAFEF00D, 1'b0, 32'h0,        1};
    vecs[7]  = '{1'b0, 1'b0, 32'h3FC,      32'h0,        1'b0, 32'hCAFEF00D, 1};
    vecs[8]  = '{1'b0, 1'b1, 32'h400,      32'hA5A5A5A5, 1'b1, 32'h0,        0};
    vecs[9]  = '{1'b0, 1'b1, 32'h3FE,      32'h11111111, 1'b1, 32'h0,        0};
    vecs[10] = '{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1};
    vecs[11] = '{1'b0, 1'b0, 32'h3FC,      32'h0,        1'b0, 32'hCAFEF00D, 1};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h22222222, 1'b1, 32'h0,        0};
    vecs[13] = '{1'b0, 1'b0, 32'h20,       32'h0,        1'b0, 32'h12345678, 1};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    got_ack, got_err, got_rdata, lat);
      checkOutput($sformatf("vec%0d_ack", i), got_ack, 1);
      checkOutput($sformatf("vec%0d_latency", i), lat, 2);
      checkOutput($sformatf("vec%0d_err", i), got_err, vecs[i].exp_err);
      checkOutput($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_strobes", i), strobe_cnt, vecs[i].exp_strobes);
      if (vecs[i].exp_strobes != 0) begin
        checkOutput($sformatf("vec%0d_mem_address", i), strobe_addr, vecs[i].addr >> 2);
        checkOutput($sformatf("vec%0d_strobe_we", i), strobe_we, vecs[i].we);
        if (vecs[i].we) checkOutput($sformatf("vec%0d_mem_wdata", i), strobe_wdata, vecs[i].wdata);
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rdata_hold", i), vecs[i].port ? rdata1 : rdata0, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_idle", i), busy, 0);
    end

    // Simultaneous requests from reset: port 0 first, then port 1.
    doReset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    runWindow(6, 1'b1, 1'b1, 0);
    checkOutput("tie_count", ack_log.size(), 2);
    checkAck("tie_a0", 0, 2, 0, 32'hDEADBEEF);
    checkAck("tie_a1", 1, 5, 1, 32'h12345678);

    // Both held: grants alternate.
    req0 = 1'b1; req1 = 1'b1;
    runWindow(12, 1'b0, 1'b0, 0);
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("alt_count", ack_log.size(), 4);
    checkAck("alt_a0", 0, 2, 0, 32'hDEADBEEF);
    checkAck("alt_a1", 1, 5, 1, 32'h12345678);
    checkAck("alt_a2", 2, 8, 0, 32'hDEADBEEF);
    checkAck("alt_a3", 3, 11, 1, 32'h12345678);
    @(negedge clk);
    checkOutput("alt_idle", busy, 0);

    // Port 0 hogs the bus; port 1 still gets the next slot.
    req0 = 1'b1;
    runWindow(12, 1'b0, 1'b1, 1);
    req0 = 1'b0;
    checkOutput("starve_count", ack_log.size(), 4);
    checkAck("starve_a0", 0, 2, 0, 32'hDEADBEEF);
    checkAck("starve_a1", 1, 5, 1, 32'h12345678);
    checkAck("starve_a2", 2, 8, 0, 32'hDEADBEEF);
    checkAck("starve_a3", 3, 11, 0, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("starve_idle", busy, 0);

    // Reset during the access cycle of a write aborts it.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h12345678;
    @(negedge clk);
    checkOutput("abort_access_busy", busy, 1);
    checkOutput("abort_access_write", mem_write, 1);
    checkOutput("abort_access_addr", mem_address, 8);
    rst = 1'b1; req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    checkOutput("abort_no_ack", ack0, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_no_write", mem_write, 0);
    checkOutput("abort_rdata_clear", rdata0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, got_ack, got_err, got_rdata, lat);
    checkOutput("after_abort_ack", got_ack, 1);
    checkOutput("after_abort_latency", lat, 2);
    checkOutput("after_abort_err", got_err, 0);
    checkOutput("after_abort_rdata", got_rdata, 32'h12345678);

    // Back-to-back: req0 held through ack repeats every 3 cycles.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    runWindow(9, 1'b0, 1'b0, 0);
    req0 = 1'b0;
    checkOutput("b2b_count", ack_log.size(), 3);
    checkAck("b2b_a0", 0, 2, 0, 32'hDEADBEEF);
    checkAck("b2b_a1", 1, 5, 0, 32'hDEADBEEF);
    checkAck("b2b_a2", 2, 8, 0, 32'hDEADBEEF);

    // Randomized traffic against a transaction-timing reference model.
    doReset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    pend[0] = 1'b0; pend[1] = 1'b0;
    next_slot = 1; exp_ack_cyc = -1; exp_port = 0; last = 1;
    x_we = 1'b0; x_bad = 1'b0; x_addr = 32'h0; x_wdata = 32'h0;
    for (int c = 1; c <= 412; c++) begin
      @(negedge clk);
      just_done[0] = 1'b0; just_done[1] = 1'b0;
      exp_acks = (c == exp_ack_cyc) ? ((exp_port == 1) ? 2'b10 : 2'b01) : 2'b00;
      checkOutput("rand_acks", {ack1, ack0}, exp_acks);
      if (c == exp_ack_cyc) begin
        x_rdata = (x_we || x_bad) ? 32'h0 : ref_mem[x_addr / 4];
        if (!x_we || x_bad) begin
        end else begin
          ref_mem[x_addr / 4] = x_wdata;
        end
        checkOutput("rand_err", (exp_port == 1) ? err1 : err0, x_bad);
        checkOutput("rand_rdata", (exp_port == 1) ? rdata1 : rdata0, x_rdata);
        pend[exp_port] = 1'b0;
        just_done[exp_port] = 1'b1;
        if (exp_port == 1) req1 = 1'b0; else req0 = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (c <= 400 && !pend[p] && !just_done[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1'b1;
          r_we[p]    = 1'($urandom_range(0, 1));
          r_addr[p]  = randAddr();
          r_wdata[p] = $urandom;
          if (p == 1) begin
            req1 = 1'b1; we1 = r_we[p]; addr1 = r_addr[p]; wdata1 = r_wdata[p];
          end else begin
            req0 = 1'b1; we0 = r_we[p]; addr0 = r_addr[p]; wdata0 = r_wdata[p];
          end
        end
      end
      if (c >= next_slot && (pend[0] || pend[1])) begin
        exp_port    = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
        last        = exp_port;
        exp_ack_cyc = c + 2;
        next_slot   = c + 3;
        x_we    = r_we[exp_port];
        x_addr  = r_addr[exp_port];
        x_wdata = r_wdata[exp_port];
        x_bad   = (x_addr % 4 != 0) || ((x_addr / 4) >= 256);
      end
    end
    checkOutput("rand_drained", pend[0] || pend[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256-word data memory between two requesters: port 0 is the core load/store path, port 1 is the program loader / debug path.
- Each transaction uses a req/ack handshake.
- The block serialises accesses, applies round-robin fairness, range- and alignment-checks byte addresses, and converts them to word indices for the memory.
- The data memory has one-cycle registered read latency: it samples strobes on a clk edge, and read data is valid after that edge.

Parameters:
- DEPTH, 256, number of 32-bit words in the data memory (power of two).
- AW, 32, requester byte-address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  port 0 request; held until ack0.
- we0  input  1  port 0 write (1) / read (0).
- addr0  input  AW  port 0 byte address.
- wdata0  input  DW  port 0 write data.
- ack0  output  1  port 0 one-cycle completion pulse.
- err0  output  1  port 0 error, valid with ack0.
- rdata0  output  DW  port 0 read data, valid with ack0.
- req1, we1, addr1, wdata1, ack1, err1, rdata1: same as port 0, for port 1.
- mem_address  output  32  word index to the memory, zero-extended.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_write_data  output  DW  memory write data.
- mem_read_data  input  DW  memory read data, valid the cycle after mem_read is sampled.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: synchronous, active-high.
  - All outputs are driven to 0.
  - State goes to IDLE.
  - The last-grant register is set to 1, so port 0 wins the first tie.
- Reset mid-transaction aborts it: no ack is issued, and strobes drop on the next edge.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick a winner:
    - Exactly one req high: that port wins.
    - Both high: the port not granted last wins.
  - On the edge, register the winner's id, we, address and wdata; update last-grant; go to ACCESS.
- Address check, performed in IDLE on the winner:
  - word index = addr >> 2.
  - bad = (addr[1:0] != 0) OR (word index >= DEPTH).
- ACCESS (exactly one cycle):
  - mem_address = registered word index; mem_write_data = registered wdata.
  - If not bad: mem_read = ~we and mem_write = we.
  - If bad: both strobes stay 0, so memory is untouched.
  - Next state is RESP.
- RESP (exactly one cycle):
  - ack and err of the winning port are driven; err = bad.
  - Winning port's rdata:
    - Good read: mem_read_data.
    - Write or bad access: 0.
  - rdata holds its value until that port's next ack.
  - Strobes are 0.
  - Next state is IDLE.
- Latency: req sampled in cycle N, strobes in cycle N+1, ack in cycle N+2. Throughput is one transaction per 3 cycles.
- A req still high in the cycle after its ack is a new request. Requesters must drop req in the ack cycle to avoid a repeat.
- A req dropped, or addr/we/wdata changed, after the grant edge has no effect: the transaction completes with the latched values and ack is still pulsed.
- A losing requester keeps waiting. Round-robin guarantees it the next grant, so maximum wait is one transaction.
- ack0 and ack1 are never high in the same cycle.
- mem_read and mem_write are never both high.
- Strobes are only high in ACCESS.

Test Plan:
- Reset, then port 0 writes addr 0x10 with 0xDEADBEEF, then reads 0x10 → mem_write high for one cycle with mem_address=4; read ack0 arrives 2 cycles after req with rdata0=0xDEADBEEF and err0=0.
- req0 and req1 asserted together from reset, both reads, held until ack → first ack0, then ack1 three cycles later. Repeat with both held → order alternates 0,1,0,1.
- Port 1 reads addr 0x400 (index 256) and addr 0x13 (misaligned) → no strobes in ACCESS; ack1 with err1=1 and rdata1=0; memory contents unchanged on readback.
- Port 0 keeps req0 high continuously while port 1 requests once → port 1 is granted in the IDLE after port 0's first transaction; no starvation.
- rst asserted during ACCESS of a write → no ack; busy=0 on the next cycle. After release, a fresh read of 0x20 completes normally with ack0 two cycles after req.
- Back-to-back: port 0 holds req0 through ack0 → a second identical transaction starts in the following IDLE cycle; ack0 pulses every 3 cycles.
